two_port_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 2:1 word datapath.
- Two requesters each present a word and a request. The block grants one requester at a time and drives the select of the team's parameterized 2:1 behavioral multiplexer, which is instantiated inside.
- It registers the selected word, with a valid flag, for the downstream consumer.
- Sits between the two word producers and the single downstream register/consumer.

---
 rtl/two_port_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/two_port_arbiter.sv
// two_port_arbiter
//   Round-robin arbiter for two word producers sharing one 2:1 datapath.
//   Grants one requester at a time, steers the internal 2:1 mux and
//   registers the transferred word with a valid flag for the consumer.
//   A grant is held for at most HOLD_CYCLES beats while the other side waits.
//   Optional feature macro: TWO_PORT_ARBITER_COUNT_EN adds a 16-bit
//   saturating Beat_Count output (total beats since reset).
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | no grant; waiting for a request
//   S_GRANT_0 | requester 0 owns the datapath (Selector = 0)
//   S_GRANT_1 | requester 1 owns the datapath (Selector = 1)

module two_port_arbiter_mux2 #(
   parameter int WIDTH = 8
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);
   // Behavioral 2:1 select, 1 picks i_b.
   assign o_y = i_sel ? i_b : i_a;
endmodule

module two_port_arbiter #(
   parameter int WORD_LENGTH = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Req_0,
   input  logic                   Req_1,
   input  logic [WORD_LENGTH-1:0] Data_0,
   input  logic [WORD_LENGTH-1:0] Data_1,
   output logic                   Grant_0,
   output logic                   Grant_1,
   output logic                   Selector,
   output logic [WORD_LENGTH-1:0] Data_Out,
   output logic                   Data_Valid
`ifdef TWO_PORT_ARBITER_COUNT_EN
   ,
   output logic [15:0]            Beat_Count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_0 = 2'd1,
      S_GRANT_1 = 2'd2
   } state_t;

   localparam logic [7:0] LP_HOLD      = 8'(HOLD_CYCLES);
   localparam logic [7:0] LP_HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_last;
   logic [7:0]             r_count;
   logic [WORD_LENGTH-1:0] r_data_out;
   logic                   r_data_valid;
   logic                   w_beat;
   logic                   w_grant_0;
   logic                   w_grant_1;
   logic                   w_sel;
   logic                   w_hold_reached;
   logic                   w_enter_grant;
   logic [WORD_LENGTH-1:0] w_mux_out;

   // The current beat exhausts the hold budget once the count sits at
   // HOLD-1 (this beat reaches HOLD) or is already saturated at HOLD.
   assign w_hold_reached = (r_count >= LP_HOLD_LAST);
   assign w_enter_grant  = (w_next_state != r_state) && (w_next_state != S_IDLE);

   two_port_arbiter_mux2 #(
      .WIDTH (WORD_LENGTH)
   ) u_mux (
      .i_sel (w_sel),
      .i_a   (Data_0),
      .i_b   (Data_1),
      .o_y   (w_mux_out)
   );

   // Next-state and Moore output decode.
   always_comb begin
      w_next_state = r_state;
      w_grant_0    = 1'b0;
      w_grant_1    = 1'b0;
      w_sel        = 1'b0;
      w_beat       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Req_0 && Req_1) begin
               w_next_state = r_last ? S_GRANT_0 : S_GRANT_1;
            end else if (Req_0) begin
               w_next_state = S_GRANT_0;
            end else if (Req_1) begin
               w_next_state = S_GRANT_1;
            end
         end
         S_GRANT_0: begin
            w_grant_0 = 1'b1;
            w_beat    = Req_0;
            if (!Req_0) begin
               w_next_state = Req_1 ? S_GRANT_1 : S_IDLE;
            end else if (w_hold_reached && Req_1) begin
               w_next_state = S_GRANT_1;
            end
         end
         S_GRANT_1: begin
            w_grant_1 = 1'b1;
            w_sel     = 1'b1;
            w_beat    = Req_1;
            if (!Req_1) begin
               w_next_state = Req_0 ? S_GRANT_0 : S_IDLE;
            end else if (w_hold_reached && Req_0) begin
               w_next_state = S_GRANT_0;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Round-robin pointer and per-grant beat counter (saturates at HOLD).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last  <= 1'b1;
         r_count <= 8'd0;
      end else if (w_enter_grant) begin
         r_last  <= (w_next_state == S_GRANT_1);
         r_count <= 8'd0;
      end else if (w_beat && (r_count != LP_HOLD)) begin
         r_count <= r_count + 8'd1;
      end
   end

   // Output word register; valid only in the cycle after a beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
      end else if (w_beat) begin
         r_data_out   <= w_mux_out;
         r_data_valid <= 1'b1;
      end else begin
         r_data_valid <= 1'b0;
      end
   end

`ifdef TWO_PORT_ARBITER_COUNT_EN
   logic [15:0] r_beat_count;

   // Lifetime beat total, sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_beat_count <= 16'd0;
      end else if (w_beat && (r_beat_count != 16'hFFFF)) begin
         r_beat_count <= r_beat_count + 16'd1;
      end
   end

   assign Beat_Count = r_beat_count;
`endif

   assign Grant_0    = w_grant_0;
   assign Grant_1    = w_grant_1;
   assign Selector   = w_sel;
   assign Data_Out   = r_data_out;
   assign Data_Valid = r_data_valid;

endmodule
